dhnf: RTL and testbench
=======================

# dhnf

Data-hazard and forwarding unit for the 5-stage RV32I pipeline. It consumes the per-instruction read/write enables that the control unit derives in ID, together with the ID-stage register addresses. It keeps a shadow record of in-flight writers in EX, MEM and WB. From that record it produces the IF/ID stall request, the EX-stage operand forward selects and a bubble-insert control for ID/EX.

## Interface
Parameters:
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  reset, asynchronous, active-low.
- id_valid_i  input  1  ID holds a real instruction.
- id_reg1_raddr_i  input  5  rs1 of ID instruction.
- id_reg2_raddr_i  input  5  rs2 of ID instruction.
- id_rd_i  input  5  rd of ID instruction.
- cu_reg1_RE_i  input  1  ID instruction reads rs1.
- cu_reg2_RE_i  input  1  ID instruction reads rs2.
- cu_reg_we_i  input  1  ID instruction writes rd.
- id_is_load_i  input  1  ID opcode is Itype_L.
- ex_flush_i  input  1  taken branch/jump resolved in EX; kill ID.
- mem_hold_i  input  1  memory wait; freeze whole pipeline.
- dhnf_stall_o  output  1  hold PC and IF/ID (combinational).
- dhnf_bubble_o  output  1  load NOP into ID/EX this cycle (combinational).
- dhnf_fwd_a_o  output  2  EX operand A select (registered): 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- dhnf_fwd_b_o  output  2  EX operand B select, same encoding.
- dhnf_stall_cnt_o  output  CNT_W  count of load-use stall cycles, saturating.

## Operation
- Shadow entries e_ex, e_mem, e_wb, each {v, rd[4:0], ld}. Each entry describes the instruction currently in that stage.
- rd==0 is never a hazard. An entry with rd==0 or v==0 matches nothing.
- Read requests: r1 = id_valid_i & cu_reg1_RE_i & rs1!=0. r2 is the same with rs2 and cu_reg2_RE_i.
- Load-use hazard (lu): (r1 & rs1==e_ex.rd | r2 & rs2==e_ex.rd) & e_ex.v & e_ex.ld.
- dhnf_stall_o = lu & ~ex_flush_i.
- dhnf_bubble_o = lu | ex_flush_i.
- Forward select for rs1, computed in ID and registered when the instruction advances:
  - rs1 matches e_ex (non-load): 01.
  - else rs1 matches e_mem: 10.
  - else: 00.
  - A match with e_ex takes priority over e_mem.
  - rs2 uses the same rule.
- Matches with e_wb need no forward: the register file bypasses a same-cycle write to a read.
- Advance, when mem_hold_i==0:
  - e_wb <= e_mem; e_mem <= e_ex.
  - e_ex <= {id_valid_i & cu_reg_we_i & ~bubble, id_rd_i, id_is_load_i}, where bubble = dhnf_bubble_o.
  - dhnf_fwd_a/b_o <= computed selects, or 00 if bubble.
- Freeze, when mem_hold_i==1:
  - All entries and fwd outputs hold.
  - dhnf_stall_o and dhnf_bubble_o are still driven, but the pipeline ignores them while held.
  - The stall counter does not increment.
- Counter: +1 on each cycle with dhnf_stall_o & ~mem_hold_i. It saturates at all-ones.
- Simultaneous ex_flush_i and lu: the flush wins. There is no stall, the ID instruction is killed, and the counter is not incremented.

## Timing
- Reset values: all entry v=0, rd=0, ld=0; dhnf_fwd_a_o = dhnf_fwd_b_o = 00; dhnf_stall_cnt_o = 0. dhnf_stall_o and dhnf_bubble_o are 0 because no entry is valid.
- Asynchronous reset mid-operation clears everything immediately. The first post-reset cycle sees an empty pipeline.
- Load-use costs exactly one stall cycle:
  - Cycle N: load in EX, consumer in ID. stall=1, bubble=1.
  - Cycle N+1: load in MEM, consumer still in ID. No stall; the consumer's select is latched as 10.
  - Cycle N+2: consumer in EX with fwd=10.
- ALU-to-ALU dependence: zero stall. fwd=01 is valid in the cycle the consumer occupies EX.
- Forward outputs are registered, so they change only on clk rising edge with mem_hold_i==0.

## Test plan
- Back-to-back dependence: `add x5,..` then `add x6,x5,x5`. Required: no stall; consumer in EX with fwd_a=01 and fwd_b=01.
- Distance 2: `add x5`, unrelated instruction, `sub x7,x5,x1`. Required: consumer fwd_a=10, fwd_b=00. At distance 3: fwd_a=00 (regfile bypass).
- Load-use: `lw x8`, then `addi x9,x8,1`. Required: stall=1 and bubble=1 for exactly one cycle; consumer reaches EX with fwd_a=10; stall_cnt goes 0→1.
- x0 and non-reading cases:
  - Writer to x0 followed by a reader of x0: fwd=00, no stall.
  - `lw x8` followed by `lui x8`, which has RE=0: no stall.
- Flush during load-use: ex_flush_i=1 in the same cycle as lu. Required: stall=0, bubble=1, the killed instruction never creates an e_ex entry, and stall_cnt is unchanged.
- Hold and saturation:
  - mem_hold_i held 3 cycles mid-hazard: entries and fwd outputs are frozen and the counter is unchanged.
  - With CNT_W=2, 5 load-use stalls: counter ends at 3.
  - Asserting rst_n=0 mid-stream clears all outputs asynchronously.

Source files
------------

// File: rtl/dhnf.sv
// rtl/dhnf.sv - data-hazard detection and EX operand forwarding for the 5-stage RV32I pipeline
module dhnf #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [4:0]       id_reg1_raddr_i,
    input  logic [4:0]       id_reg2_raddr_i,
    input  logic [4:0]       id_rd_i,
    input  logic             cu_reg1_RE_i,
    input  logic             cu_reg2_RE_i,
    input  logic             cu_reg_we_i,
    input  logic             id_is_load_i,
    input  logic             ex_flush_i,
    input  logic             mem_hold_i,
    output logic             dhnf_stall_o,
    output logic             dhnf_bubble_o,
    output logic [1:0]       dhnf_fwd_a_o,
    output logic [1:0]       dhnf_fwd_b_o,
    output logic [CNT_W-1:0] dhnf_stall_cnt_o
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Shadow record of the writer currently occupying each later stage.
    logic       ex_v;
    logic [4:0] ex_rd;
    logic       ex_ld;
    logic       mem_v;
    logic [4:0] mem_rd;
    logic       wb_v;
    logic [4:0] wb_rd;

    logic       rd1_req, rd2_req;
    logic       hit1_ex, hit1_mem, hit1_wb;
    logic       hit2_ex, hit2_mem, hit2_wb;
    logic       load_use;
    logic [1:0] sel_a, sel_b;

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                           input logic hit_wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_ex)
            sel = FWD_EXMEM;
        else if (hit_mem)
            sel = FWD_MEMWB;
        else if (hit_wb)
            sel = FWD_RF;   // register file writes through to a same-cycle read
        return sel;
    endfunction

    // A nonzero read address can only equal a nonzero rd, so x0 never matches.
    always_comb begin
        rd1_req  = id_valid_i & cu_reg1_RE_i & (id_reg1_raddr_i != 5'd0);
        rd2_req  = id_valid_i & cu_reg2_RE_i & (id_reg2_raddr_i != 5'd0);
        hit1_ex  = rd1_req & ex_v  & (ex_rd  == id_reg1_raddr_i);
        hit1_mem = rd1_req & mem_v & (mem_rd == id_reg1_raddr_i);
        hit1_wb  = rd1_req & wb_v  & (wb_rd  == id_reg1_raddr_i);
        hit2_ex  = rd2_req & ex_v  & (ex_rd  == id_reg2_raddr_i);
        hit2_mem = rd2_req & mem_v & (mem_rd == id_reg2_raddr_i);
        hit2_wb  = rd2_req & wb_v  & (wb_rd  == id_reg2_raddr_i);
        load_use = ex_ld & (hit1_ex | hit2_ex);
        dhnf_stall_o  = load_use & ~ex_flush_i;
        dhnf_bubble_o = load_use | ex_flush_i;
        sel_a = fwd_sel(hit1_ex, hit1_mem, hit1_wb);
        sel_b = fwd_sel(hit2_ex, hit2_mem, hit2_wb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v             <= 1'b0;
            ex_rd            <= 5'd0;
            ex_ld            <= 1'b0;
            mem_v            <= 1'b0;
            mem_rd           <= 5'd0;
            wb_v             <= 1'b0;
            wb_rd            <= 5'd0;
            dhnf_fwd_a_o     <= FWD_RF;
            dhnf_fwd_b_o     <= FWD_RF;
            dhnf_stall_cnt_o <= '0;
        end else if (!mem_hold_i) begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= id_valid_i & cu_reg_we_i & ~dhnf_bubble_o;
            ex_rd  <= id_rd_i;
            ex_ld  <= id_is_load_i;
            dhnf_fwd_a_o <= dhnf_bubble_o ? FWD_RF : sel_a;
            dhnf_fwd_b_o <= dhnf_bubble_o ? FWD_RF : sel_b;
            if (dhnf_stall_o && (dhnf_stall_cnt_o != {CNT_W{1'b1}}))
                dhnf_stall_cnt_o <= dhnf_stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_dhnf.sv
// tb/tb_dhnf.sv - vector table, corner sequences and random model check for dhnf
module tb_dhnf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        re1 = 1'b0, re2 = 1'b0, we = 1'b0, ld = 1'b0, flush = 1'b0, hold = 1'b0;
    logic        stall, bubble, stall2, bubble2;
    logic [1:0]  fa, fb, fa2, fb2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    dhnf #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
        .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2), .id_rd_i(rd),
        .cu_reg1_RE_i(re1), .cu_reg2_RE_i(re2), .cu_reg_we_i(we),
        .id_is_load_i(ld), .ex_flush_i(flush), .mem_hold_i(hold),
        .dhnf_stall_o(stall), .dhnf_bubble_o(bubble),
        .dhnf_fwd_a_o(fa), .dhnf_fwd_b_o(fb), .dhnf_stall_cnt_o(cnt)
    );

    dhnf #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
        .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2), .id_rd_i(rd),
        .cu_reg1_RE_i(re1), .cu_reg2_RE_i(re2), .cu_reg_we_i(we),
        .id_is_load_i(ld), .ex_flush_i(flush), .mem_hold_i(hold),
        .dhnf_stall_o(stall2), .dhnf_bubble_o(bubble2),
        .dhnf_fwd_a_o(fa2), .dhnf_fwd_b_o(fb2), .dhnf_stall_cnt_o(cnt2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic v; logic [4:0] rs1, rs2, rd;
        logic re1, re2, we, ld, fl, hd;
        logic st, bb; logic [1:0] fa, fb; int cnt;
    } vec_t;

    function automatic vec_t mk(input int v, a, b, d, e1, e2, w, l, f, h,
                                input int st, bb, xa, xb, c);
        vec_t t;
        t.v = v[0]; t.rs1 = a[4:0]; t.rs2 = b[4:0]; t.rd = d[4:0];
        t.re1 = e1[0]; t.re2 = e2[0]; t.we = w[0]; t.ld = l[0]; t.fl = f[0]; t.hd = h[0];
        t.st = st[0]; t.bb = bb[0]; t.fa = xa[1:0]; t.fb = xb[1:0]; t.cnt = c;
        return t;
    endfunction

    // Reference model: list of in-flight writers, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct { logic v; logic [4:0] rd; logic ld; } ins_t;
    ins_t       pipe [3];
    logic [1:0] m_fa, m_fb;
    int         m_cnt;

    function automatic logic [1:0] m_sel(input logic rq, input logic [4:0] rs);
        for (int d = 0; d < 2; d++)
            if (rq && rs != 0 && pipe[d].v && pipe[d].rd == rs)
                return (d == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 1'b0};
        m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
    endtask

    task automatic cycle(input logic v, input logic [4:0] a, b, d,
                         input logic e1, e2, w, l, f, h);
        logic q1, q2, lu, xs, xb;
        logic [1:0] na, nb;
        id_valid = v; rs1 = a; rs2 = b; rd = d;
        re1 = e1; re2 = e2; we = w; ld = l; flush = f; hold = h;
        q1 = v & e1 & (a != 0);
        q2 = v & e2 & (b != 0);
        lu = pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
             ((q1 && a == pipe[0].rd) || (q2 && b == pipe[0].rd));
        xs = lu & ~f;
        xb = lu | f;
        na = m_sel(q1, a);
        nb = m_sel(q2, b);
        @(negedge clk);
        check("m_stall", stall, xs);
        check("m_bubble", bubble, xb);
        check("m_fwd_a", fa, m_fa);
        check("m_fwd_b", fb, m_fb);
        check("m_cnt", cnt, m_cnt);
        check("m_cnt_sat", cnt2, (m_cnt > 3) ? 3 : m_cnt);
        @(posedge clk);
        if (!h) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v & w & ~xb, d, l};
            m_fa = xb ? 2'b00 : na;
            m_fb = xb ? 2'b00 : nb;
            if (xs) m_cnt++;
        end
        #1;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        id_valid = 1'b0; flush = 1'b0; hold = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_fwd_a", fa, 0);
        check("rst_fwd_b", fb, 0);
        check("rst_cnt", cnt, 0);
        check("rst_cnt_sat", cnt2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
    endtask

    vec_t tbl [26];

    initial begin
        //            v rs1 rs2 rd re1 re2 we ld fl hd | st bb fa fb cnt
        tbl[0]  = mk(1,  1,  2,  5, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1,  5,  5,  6, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1,  5,  1,  7, 1, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
        tbl[3]  = mk(1,  5,  0, 11, 1, 1, 1, 0, 0, 0,  0, 0, 2, 0, 0);
        tbl[4]  = mk(1,  2,  0,  8, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk(1,  8,  0,  9, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0);
        tbl[6]  = mk(1,  8,  0,  9, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[7]  = mk(1,  2,  0,  8, 1, 0, 1, 1, 0, 0,  0, 0, 2, 0, 1);
        tbl[8]  = mk(1,  8,  8,  8, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[9]  = mk(1,  1,  0,  0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[10] = mk(1,  0,  0, 13, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[11] = mk(1,  3,  0, 14, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[12] = mk(1, 14, 14, 15, 1, 1, 1, 0, 1, 0,  0, 1, 0, 0, 1);
        tbl[13] = mk(1, 15, 14, 16, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[14] = mk(1, 16, 16, 17, 1, 1, 1, 0, 0, 1,  0, 0, 0, 2, 1);
        tbl[15] = mk(1, 16, 16, 17, 1, 1, 1, 0, 0, 1,  0, 0, 0, 2, 1);
        tbl[16] = mk(1, 16, 16, 17, 1, 1, 1, 0, 0, 1,  0, 0, 0, 2, 1);
        tbl[17] = mk(1, 16, 16, 17, 1, 1, 1, 0, 0, 0,  0, 0, 0, 2, 1);
        tbl[18] = mk(1,  0,  0, 20, 0, 0, 1, 1, 0, 0,  0, 0, 1, 1, 1);
        tbl[19] = mk(1, 20,  0, 21, 1, 1, 1, 0, 0, 1,  1, 1, 0, 0, 1);
        tbl[20] = mk(1, 20,  0, 21, 1, 1, 1, 0, 0, 1,  1, 1, 0, 0, 1);
        tbl[21] = mk(1, 20,  0, 21, 1, 1, 1, 0, 0, 1,  1, 1, 0, 0, 1);
        tbl[22] = mk(1, 20,  0, 21, 1, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1);
        tbl[23] = mk(1, 20,  0, 21, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2);
        tbl[24] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 2);
        tbl[25] = mk(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 2);

        #2;
        check("reset_stall", stall, 0);
        check("reset_bubble", bubble, 0);
        check("reset_fwd_a", fa, 0);
        check("reset_fwd_b", fb, 0);
        check("reset_cnt", cnt, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            id_valid = tbl[i].v; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rd = tbl[i].rd;
            re1 = tbl[i].re1; re2 = tbl[i].re2; we = tbl[i].we; ld = tbl[i].ld;
            flush = tbl[i].fl; hold = tbl[i].hd;
            @(negedge clk);
            check($sformatf("t%0d_stall", i), stall, tbl[i].st);
            check($sformatf("t%0d_bubble", i), bubble, tbl[i].bb);
            check($sformatf("t%0d_fwd_a", i), fa, tbl[i].fa);
            check($sformatf("t%0d_fwd_b", i), fb, tbl[i].fb);
            check($sformatf("t%0d_cnt", i), cnt, tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        mid_reset();

        // Five load-use stalls: wide counter reaches 5, 2-bit counter sticks at 3.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 5'd2, 5'd0, 5'd8, 1, 0, 1, 1, 0, 0);
            cycle(1, 5'd8, 5'd0, 5'd9, 1, 0, 1, 0, 0, 0);
            cycle(1, 5'd8, 5'd0, 5'd9, 1, 0, 1, 0, 0, 0);
        end
        check("sat_cnt_wide", cnt, 5);
        check("sat_cnt_2bit", cnt2, 3);

        mid_reset();

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
